mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between the IF-stage fetch requester and the MEM-stage LSU.

---
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 96 +++++++++
 tb/tb_mem_port_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the IF fetch port, the MEM-stage LSU port and the shared memory.
// slave = arbiter view, master = surrounding pipeline/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_if_req;
    logic [ADDR_W-1:0]     i_if_addr;
    logic                  o_if_gnt;
    logic                  o_if_rvalid;
    logic [DATA_W-1:0]     o_if_rdata;

    logic                  i_ls_req;
    logic                  i_ls_wren;
    logic [ADDR_W-1:0]     i_ls_addr;
    logic [DATA_W-1:0]     i_ls_wdata;
    logic [DATA_W/8-1:0]   i_ls_bmask;
    logic                  o_ls_gnt;
    logic                  o_ls_rvalid;
    logic [DATA_W-1:0]     o_ls_rdata;

    logic                  o_mem_req;
    logic                  o_mem_wren;
    logic [ADDR_W-1:0]     o_mem_addr;
    logic [DATA_W-1:0]     o_mem_wdata;
    logic [DATA_W/8-1:0]   o_mem_bmask;
    logic                  i_mem_gnt;
    logic                  i_mem_rvalid;
    logic [DATA_W-1:0]     i_mem_rdata;

    logic [31:0]           o_perf_if_wait;
    logic [31:0]           o_perf_ls_wait;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_ls_req, i_ls_wren, i_ls_addr, i_ls_wdata, i_ls_bmask,
        output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        output o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
        input  i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        output o_perf_if_wait, o_perf_ls_wait
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_ls_req, i_ls_wren, i_ls_addr, i_ls_wdata, i_ls_bmask,
        input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        input  o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask,
        output i_mem_gnt, i_mem_rvalid, i_mem_rdata,
        input  o_perf_if_wait, o_perf_ls_wait
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/LSU arbiter for a single-port memory: LSU-first priority, fetch anti-starvation, one read in flight.
// Optional wait-cycle counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int BM_W = DATA_W / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, RD_IF, RD_LS} state_t;

    state_t     state;
    logic       lock;
    logic       lock_ls;
    logic [3:0] starve_cnt;

    logic pick_ls, sel_ls, sel_if, mem_req, if_gnt, ls_gnt;

    always_comb begin
        pick_ls = bus.i_ls_req && !((starve_cnt == STARVE_LIM) && bus.i_if_req);
        // while locked the choice made at request time is held until memory acks it
        sel_ls  = (state == IDLE) && (lock ? lock_ls  : pick_ls);
        sel_if  = (state == IDLE) && (lock ? !lock_ls : (!pick_ls && bus.i_if_req));
        mem_req = (sel_ls && bus.i_ls_req) || (sel_if && bus.i_if_req);
        if_gnt  = sel_if && bus.i_if_req && bus.i_mem_gnt;
        ls_gnt  = sel_ls && bus.i_ls_req && bus.i_mem_gnt;
    end

    assign bus.o_mem_req   = mem_req;
    assign bus.o_mem_wren  = sel_ls && bus.i_ls_wren;
    assign bus.o_mem_addr  = sel_ls ? bus.i_ls_addr : (sel_if ? bus.i_if_addr : {ADDR_W{1'b0}});
    assign bus.o_mem_wdata = sel_ls ? bus.i_ls_wdata : {DATA_W{1'b0}};
    assign bus.o_mem_bmask = sel_ls ? bus.i_ls_bmask : {BM_W{1'b0}};
    assign bus.o_if_gnt    = if_gnt;
    assign bus.o_ls_gnt    = ls_gnt;

    // responses are only accepted while the matching read is outstanding
    assign bus.o_if_rvalid = (state == RD_IF) && bus.i_mem_rvalid;
    assign bus.o_ls_rvalid = (state == RD_LS) && bus.i_mem_rvalid;
    assign bus.o_if_rdata  = bus.o_if_rvalid ? bus.i_mem_rdata : {DATA_W{1'b0}};
    assign bus.o_ls_rdata  = bus.o_ls_rvalid ? bus.i_mem_rdata : {DATA_W{1'b0}};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            lock       <= 1'b0;
            lock_ls    <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req && !bus.i_mem_gnt) begin
                        lock    <= 1'b1;
                        lock_ls <= sel_ls;
                    end else begin
                        lock    <= 1'b0;
                    end
                    if (if_gnt)                           state <= RD_IF;
                    else if (ls_gnt && !bus.i_ls_wren)    state <= RD_LS;
                end
                RD_IF, RD_LS: if (bus.i_mem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (!bus.i_if_req || if_gnt)
                starve_cnt <= 4'd0;
            else if (ls_gnt && (starve_cnt != STARVE_LIM))
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_wait, perf_ls_wait;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            perf_if_wait <= 32'd0;
            perf_ls_wait <= 32'd0;
        end else begin
            if (bus.i_if_req && !if_gnt) perf_if_wait <= perf_if_wait + 32'd1;
            if (bus.i_ls_req && !ls_gnt) perf_ls_wait <= perf_ls_wait + 32'd1;
        end
    end

    assign bus.o_perf_if_wait = perf_if_wait;
    assign bus.o_perf_ls_wait = perf_ls_wait;
`else
    assign bus.o_perf_if_wait = 32'd0;
    assign bus.o_perf_ls_wait = 32'd0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
    localparam int STARVE_MAX = 4;
`ifdef ARB_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_if_req = 0; bus.i_if_addr = 0;
        bus.i_ls_req = 0; bus.i_ls_wren = 0; bus.i_ls_addr = 0;
        bus.i_ls_wdata = 0; bus.i_ls_bmask = 0;
        bus.i_mem_gnt = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = 0;
    endtask

    task automatic do_reset();
        @(posedge i_clk); #1;
        i_reset = 1; clear_inputs();
        repeat (2) @(posedge i_clk);
        #1 i_reset = 0;
    endtask

    // status vector: {mem_req, mem_wren, if_gnt, ls_gnt, if_rvalid, ls_rvalid}
    function automatic logic [5:0] stat();
        return {bus.o_mem_req, bus.o_mem_wren, bus.o_if_gnt, bus.o_ls_gnt,
                bus.o_if_rvalid, bus.o_ls_rvalid};
    endfunction

    task automatic test_reset();
        clear_inputs();
        i_reset = 1;
        #2;
        n_checks++;
        if (stat() !== 6'b0 || bus.o_mem_addr !== 32'd0 || bus.o_if_rdata !== 32'd0 || bus.o_ls_rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_outputs: stat=%b addr=%h expected 000000/0", stat(), bus.o_mem_addr);
        end
        n_checks++;
        if (bus.o_perf_if_wait !== 32'd0 || bus.o_perf_ls_wait !== 32'd0) begin
            n_fail++; $display("FAIL reset_perf: if=%0d ls=%0d expected 0/0", bus.o_perf_if_wait, bus.o_perf_ls_wait);
        end
        do_reset();
    endtask

    task automatic test_fetch_only();
        do_reset();
        bus.i_if_req = 1; bus.i_if_addr = 32'h10; bus.i_mem_gnt = 1;
        #3; n_checks++;
        if (stat() !== 6'b101000 || bus.o_mem_addr !== 32'h10) begin
            n_fail++; $display("FAIL fetch_gnt_c0: stat=%b addr=%h expected 101000/00000010", stat(), bus.o_mem_addr);
        end
        tick(); bus.i_if_req = 0; bus.i_mem_gnt = 0;
        #3; n_checks++;
        if (stat() !== 6'b0) begin
            n_fail++; $display("FAIL fetch_wait_c1: stat=%b expected 000000", stat());
        end
        tick(); bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'h513;
        #3; n_checks++;
        if (stat() !== 6'b000010 || bus.o_if_rdata !== 32'h513) begin
            n_fail++; $display("FAIL fetch_rvalid_c2: stat=%b rdata=%h expected 000010/00000513", stat(), bus.o_if_rdata);
        end
        tick(); bus.i_mem_rvalid = 0;
        bus.i_ls_req = 1; bus.i_ls_wren = 1; bus.i_ls_addr = 32'h44; bus.i_mem_gnt = 1;
        #3; n_checks++;
        if (stat() !== 6'b110100) begin
            n_fail++; $display("FAIL fetch_idle_c3: stat=%b expected 110100", stat());
        end
        tick(); clear_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.i_if_req = 1; bus.i_if_addr = 32'h40;
        bus.i_ls_req = 1; bus.i_ls_wren = 0; bus.i_ls_addr = 32'h2000; bus.i_mem_gnt = 1;
        #3; n_checks++;
        if (stat() !== 6'b100100 || bus.o_mem_addr !== 32'h2000) begin
            n_fail++; $display("FAIL simul_ls_wins: stat=%b addr=%h expected 100100/00002000", stat(), bus.o_mem_addr);
        end
        tick(); bus.i_ls_req = 0;
        #3; n_checks++;
        if (stat() !== 6'b0) begin
            n_fail++; $display("FAIL simul_rd_ls_blocks: stat=%b expected 000000", stat());
        end
        tick(); bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'hCAFE_0001;
        #3; n_checks++;
        if (stat() !== 6'b000001 || bus.o_ls_rdata !== 32'hCAFE_0001 || bus.o_if_rdata !== 32'd0) begin
            n_fail++; $display("FAIL simul_ls_resp: stat=%b ls_rdata=%h expected 000001/cafe0001", stat(), bus.o_ls_rdata);
        end
        tick(); bus.i_mem_rvalid = 0;
        #3; n_checks++;
        if (stat() !== 6'b101000 || bus.o_mem_addr !== 32'h40) begin
            n_fail++; $display("FAIL simul_fetch_next: stat=%b addr=%h expected 101000/00000040", stat(), bus.o_mem_addr);
        end
        tick(); bus.i_if_req = 0; bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'h1111;
        #3; n_checks++;
        if (stat() !== 6'b000010 || bus.o_if_rdata !== 32'h1111) begin
            n_fail++; $display("FAIL simul_fetch_resp: stat=%b rdata=%h expected 000010/00001111", stat(), bus.o_if_rdata);
        end
        tick(); clear_inputs();
    endtask

    // fetch must win on every (STARVE_MAX+1)th arbitration against a stream of stores
    task automatic test_starvation();
        do_reset();
        bus.i_if_req = 1; bus.i_if_addr = 32'h100; bus.i_mem_gnt = 1;
        bus.i_ls_req = 1; bus.i_ls_wren = 1; bus.i_ls_bmask = 4'hF;
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < STARVE_MAX; k++) begin
                bus.i_ls_addr = 32'h3000 + 32'(round*16 + k*4); bus.i_ls_wdata = 32'h100 + 32'(round*16 + k);
                #3; n_checks++;
                if (stat() !== 6'b110100 || bus.o_mem_wdata !== bus.i_ls_wdata || bus.o_mem_bmask !== 4'hF) begin
                    n_fail++; $display("FAIL starve_ls_gnt r%0d k%0d: stat=%b wdata=%h expected 110100/%h", round, k, stat(), bus.o_mem_wdata, bus.i_ls_wdata);
                end
                tick();
            end
            #3; n_checks++;
            if (stat() !== 6'b101000 || bus.o_mem_addr !== bus.i_if_addr) begin
                n_fail++; $display("FAIL starve_fetch_forced r%0d: stat=%b addr=%h expected 101000/%h", round, stat(), bus.o_mem_addr, bus.i_if_addr);
            end
            tick(); bus.i_if_addr = bus.i_if_addr + 4; bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'h700 + 32'(round);
            #3; n_checks++;
            if (stat() !== 6'b000010 || bus.o_if_rdata !== 32'h700 + 32'(round)) begin
                n_fail++; $display("FAIL starve_fetch_resp r%0d: stat=%b rdata=%h", round, stat(), bus.o_if_rdata);
            end
            tick(); bus.i_mem_rvalid = 0;
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        bus.i_if_req = 1; bus.i_if_addr = 32'h80; bus.i_mem_gnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin bus.i_ls_req = 1; bus.i_ls_wren = 0; bus.i_ls_addr = 32'h3000; end
            #3; n_checks++;
            if (stat() !== 6'b100000 || bus.o_mem_addr !== 32'h80) begin
                n_fail++; $display("FAIL lock_hold c%0d: stat=%b addr=%h expected 100000/00000080", c, stat(), bus.o_mem_addr);
            end
            tick();
        end
        bus.i_mem_gnt = 1;
        #3; n_checks++;
        if (stat() !== 6'b101000 || bus.o_mem_addr !== 32'h80) begin
            n_fail++; $display("FAIL lock_fetch_first: stat=%b addr=%h expected 101000/00000080", stat(), bus.o_mem_addr);
        end
        tick(); bus.i_if_req = 0; bus.i_mem_gnt = 0; bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'h2222;
        #3; n_checks++;
        if (stat() !== 6'b000010 || bus.o_if_rdata !== 32'h2222) begin
            n_fail++; $display("FAIL lock_fetch_resp: stat=%b rdata=%h expected 000010/00002222", stat(), bus.o_if_rdata);
        end
        tick(); bus.i_mem_rvalid = 0; bus.i_mem_gnt = 1;
        #3; n_checks++;
        if (stat() !== 6'b100100 || bus.o_mem_addr !== 32'h3000) begin
            n_fail++; $display("FAIL lock_ls_after: stat=%b addr=%h expected 100100/00003000", stat(), bus.o_mem_addr);
        end
        tick(); bus.i_ls_req = 0; bus.i_mem_gnt = 0; bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'h3333;
        #3; n_checks++;
        if (stat() !== 6'b000001 || bus.o_ls_rdata !== 32'h3333) begin
            n_fail++; $display("FAIL lock_ls_resp: stat=%b rdata=%h expected 000001/00003333", stat(), bus.o_ls_rdata);
        end
        tick(); clear_inputs();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        bus.i_ls_req = 1; bus.i_ls_wren = 0; bus.i_ls_addr = 32'h4000; bus.i_mem_gnt = 1;
        tick(); bus.i_ls_req = 0; bus.i_mem_gnt = 0;
        i_reset = 1; bus.i_mem_rvalid = 1; bus.i_mem_rdata = 32'hDEAD;
        #3; n_checks++;
        if (stat() !== 6'b0) begin
            n_fail++; $display("FAIL rstmid_during: stat=%b expected 000000", stat());
        end
        tick(); i_reset = 0;
        bus.i_if_req = 1; bus.i_if_addr = 32'h90; bus.i_mem_gnt = 1;
        #3; n_checks++;
        if (stat() !== 6'b101000) begin
            n_fail++; $display("FAIL rstmid_spurious: stat=%b expected 101000", stat());
        end
        tick(); bus.i_if_req = 0; bus.i_mem_gnt = 0; bus.i_mem_rdata = 32'h77;
        #3; n_checks++;
        if (stat() !== 6'b000010 || bus.o_if_rdata !== 32'h77) begin
            n_fail++; $display("FAIL rstmid_fetch_resp: stat=%b rdata=%h expected 000010/00000077", stat(), bus.o_if_rdata);
        end
        tick(); clear_inputs();
    endtask

    task automatic test_perf();
        do_reset();
        bus.i_ls_req = 1; bus.i_ls_wren = 1; bus.i_ls_addr = 32'h5000; bus.i_mem_gnt = 0;
        repeat (7) tick();
        bus.i_mem_gnt = 1;
        #3; n_checks++;
        if (bus.o_ls_gnt !== 1'b1) begin
            n_fail++; $display("FAIL perf_ls_gnt: got %b expected 1", bus.o_ls_gnt);
        end
        tick(); clear_inputs();
        #1; n_checks++;
        if (bus.o_perf_ls_wait !== (PERF_ON ? 32'd7 : 32'd0) || bus.o_perf_if_wait !== 32'd0) begin
            n_fail++; $display("FAIL perf_ls_wait: ls=%0d if=%0d expected %0d/0", bus.o_perf_ls_wait, bus.o_perf_if_wait, PERF_ON ? 7 : 0);
        end
        tick();
    endtask

    // randomized traffic: owners 0=none 1=fetch 2=lsu
    task automatic test_random();
        int if_pend, ls_pend, owner, frozen, starve, wait_c, win;
        logic [31:0] if_a, ls_a, ls_d, rd_addr, exp_if_wait, exp_ls_wait;
        logic [3:0] ls_m;
        logic ls_w;
        logic [5:0] exp_stat;
        logic [31:0] exp_addr;
        do_reset();
        if_pend = 0; ls_pend = 0; owner = 0; frozen = 0; starve = 0; wait_c = 0;
        if_a = 0; ls_a = 0; ls_d = 0; ls_m = 0; ls_w = 0; rd_addr = 0;
        exp_if_wait = 0; exp_ls_wait = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (if_pend == 0 && $urandom_range(0, 2) != 0) begin
                if_pend = 1; if_a = $urandom & 32'hFFFF_FFFC;
            end
            if (ls_pend == 0 && $urandom_range(0, 2) != 0) begin
                ls_pend = 1; ls_a = $urandom; ls_d = $urandom; ls_m = 4'($urandom); ls_w = 1'($urandom);
            end
            bus.i_if_req = (if_pend != 0); bus.i_if_addr = if_a;
            bus.i_ls_req = (ls_pend != 0); bus.i_ls_addr = ls_a; bus.i_ls_wdata = ls_d;
            bus.i_ls_bmask = ls_m; bus.i_ls_wren = ls_w;
            bus.i_mem_gnt = ($urandom_range(0, 3) != 0);
            if (owner != 0) begin
                bus.i_mem_rvalid = (wait_c == 0);
                bus.i_mem_rdata = (wait_c == 0) ? (rd_addr ^ 32'h5A5A_0F0F) : $urandom;
                if (wait_c != 0) wait_c--;
            end else begin
                bus.i_mem_rvalid = ($urandom_range(0, 7) == 0);
                bus.i_mem_rdata = $urandom;
            end
            #3;
            win = 0;
            if (owner == 0) begin
                if (frozen != 0) win = frozen;
                else if (ls_pend != 0 && !(starve == STARVE_MAX && if_pend != 0)) win = 2;
                else if (if_pend != 0) win = 1;
            end
            exp_stat = {win != 0, win == 2 && ls_w, win == 1 && bus.i_mem_gnt, win == 2 && bus.i_mem_gnt,
                        owner == 1 && bus.i_mem_rvalid, owner == 2 && bus.i_mem_rvalid};
            exp_addr = (win == 2) ? ls_a : (win == 1) ? if_a : 32'd0;
            n_checks++;
            if (stat() !== exp_stat || bus.o_mem_addr !== exp_addr) begin
                n_fail++; $display("FAIL rand_cycle%0d: stat=%b addr=%h expected %b/%h", cyc, stat(), bus.o_mem_addr, exp_stat, exp_addr);
            end
            if (win == 2) begin
                n_checks++;
                if (bus.o_mem_wdata !== ls_d || bus.o_mem_bmask !== ls_m) begin
                    n_fail++; $display("FAIL rand_wdata%0d: %h/%h expected %h/%h", cyc, bus.o_mem_wdata, bus.o_mem_bmask, ls_d, ls_m);
                end
            end
            if (owner != 0 && bus.i_mem_rvalid) begin
                n_checks++;
                if ((owner == 1 ? bus.o_if_rdata : bus.o_ls_rdata) !== (rd_addr ^ 32'h5A5A_0F0F)) begin
                    n_fail++; $display("FAIL rand_rdata%0d: if=%h ls=%h expected %h", cyc, bus.o_if_rdata, bus.o_ls_rdata, rd_addr ^ 32'h5A5A_0F0F);
                end
            end
            if (if_pend != 0 && !(win == 1 && bus.i_mem_gnt)) exp_if_wait++;
            if (ls_pend != 0 && !(win == 2 && bus.i_mem_gnt)) exp_ls_wait++;
            if (if_pend == 0 || (win == 1 && bus.i_mem_gnt)) starve = 0;
            else if (win == 2 && bus.i_mem_gnt && starve < STARVE_MAX) starve++;
            if (win != 0) begin
                if (bus.i_mem_gnt) begin
                    frozen = 0;
                    wait_c = $urandom_range(0, 2);
                    if (win == 1) begin owner = 1; rd_addr = if_a; if_pend = 0; end
                    else begin
                        if (!ls_w) begin owner = 2; rd_addr = ls_a; end
                        ls_pend = 0;
                    end
                end else frozen = win;
            end else if (owner != 0 && bus.i_mem_rvalid) owner = 0;
            tick();
        end
        n_checks++;
        if (bus.o_perf_if_wait !== (PERF_ON ? exp_if_wait : 32'd0) || bus.o_perf_ls_wait !== (PERF_ON ? exp_ls_wait : 32'd0)) begin
            n_fail++; $display("FAIL rand_perf: if=%0d ls=%0d expected %0d/%0d", bus.o_perf_if_wait, bus.o_perf_ls_wait,
                               PERF_ON ? exp_if_wait : 0, PERF_ON ? exp_ls_wait : 0);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_lock();
        test_reset_mid_read();
        test_perf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
